// File: rtl/keypad_entry_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : keypad_entry_if                                              |
// | Description : Signal bundle between the keypad entry controller and its    |
// |               surroundings (encoder, consuming FSM).                       |
// |               master : drives commands and encoder signals, reads results. |
// |               slave  : the entry controller itself.                        |
// |   start/clear/commit  1-cycle command pulses                               |
// |   bcd_in/bcd_valid    encoder outputs, asynchronous to clk                 |
// |   enc_enablen         encoder enable, active low                           |
// |   digits/digit_count  packed code (newest digit in [3:0]) and its length   |
// |   code_valid/timeout  1-cycle result pulses                                |
// |   overflow/busy       sticky overflow flag, entry-in-progress flag         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface keypad_entry_if #(
  parameter int NDIGITS = 4
);
  localparam int CW = $clog2(NDIGITS + 1);

  logic                   start;
  logic                   clear;
  logic                   commit;
  logic [3:0]             bcd_in;
  logic                   bcd_valid;
  logic                   enc_enablen;
  logic [4*NDIGITS-1:0]   digits;
  logic [CW-1:0]          digit_count;
  logic                   code_valid;
  logic                   overflow;
  logic                   timeout;
  logic                   busy;

  modport master (
    output start, clear, commit, bcd_in, bcd_valid,
    input  enc_enablen, digits, digit_count, code_valid, overflow, timeout, busy
  );

  modport slave (
    input  start, clear, commit, bcd_in, bcd_valid,
    output enc_enablen, digits, digit_count, code_valid, overflow, timeout, busy
  );
endinterface
`default_nettype wire

// File: rtl/keypad_entry_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : keypad_entry_ctrl                                            |
// | Description : Multi-digit keypad entry sequencer. Arms the BCD encoder     |
// |               while an entry is open, synchronises and edge-detects its    |
// |               valid strobe, shifts accepted digits into a buffer and       |
// |               publishes the code on commit (or aborts on idle timeout).    |
// | Ports       : clk    - system clock, rising edge                           |
// |               rst_n  - asynchronous active-low reset                       |
// |               bus    - keypad_entry_if.slave (commands, encoder, results)  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module keypad_entry_ctrl #(
  parameter int NDIGITS     = 4,
  parameter int TIMEOUT_CYC = 1000,
  parameter int TMR_W       = 10
) (
  input  wire              clk,
  input  wire              rst_n,
  keypad_entry_if.slave    bus
);

  localparam int DW = 4 * NDIGITS;
  localparam int CW = $clog2(NDIGITS + 1);

  localparam logic [CW-1:0]    C_FULL     = CW'(NDIGITS);
  localparam logic [TMR_W-1:0] C_TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [3:0]       C_BCD_MAX  = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t             r_state;
  logic               r_valid_s1;
  logic               r_valid_s2;
  logic               r_valid_d;
  logic [3:0]         r_bcd_s1;
  logic [3:0]         r_bcd_s2;
  logic [DW-1:0]      r_digits;
  logic [CW-1:0]      r_count;
  logic               r_overflow;
  logic               r_timeout;
  logic [TMR_W-1:0]   r_timer;

  // --------------------------------------------------------------------------
  // Next-state / output wires
  // --------------------------------------------------------------------------
  state_t             w_state_nxt;
  logic [DW-1:0]      w_digits_nxt;
  logic [CW-1:0]      w_count_nxt;
  logic               w_overflow_nxt;
  logic               w_timeout_nxt;
  logic [TMR_W-1:0]   w_timer_nxt;
  logic               w_enc_enablen;
  logic               w_busy;
  logic               w_code_valid;
  logic               w_valid_rise;
  logic               w_accept;
  logic [DW-1:0]      w_shifted;

  // --------------------------------------------------------------------------
  // Encoder synchronisers. bcd_in rides the same two-stage path as bcd_valid
  // so the synced digit is aligned with the synced strobe; the encoder holds
  // its BCD output steady while valid is high.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid_s1 <= 1'b0;
      r_valid_s2 <= 1'b0;
      r_valid_d  <= 1'b0;
      r_bcd_s1   <= 4'd0;
      r_bcd_s2   <= 4'd0;
    end else begin
      r_valid_s1 <= bus.bcd_valid;
      r_valid_s2 <= r_valid_s1;
      r_valid_d  <= r_valid_s2;
      r_bcd_s1   <= bus.bcd_in;
      r_bcd_s2   <= r_bcd_s1;
    end
  end

  // Only the rising edge counts, so a held key yields a single digit.
  assign w_valid_rise = r_valid_s2 & ~r_valid_d;
  // Non-decimal codes (10..15) are silently discarded.
  assign w_accept     = (r_state == ST_ENTRY) && w_valid_rise && (r_bcd_s2 <= C_BCD_MAX);

  // Newest digit enters at the bottom nibble; the oldest falls off the top.
  generate
    if (NDIGITS > 1) begin : g_shift_multi
      assign w_shifted = {r_digits[DW-5:0], r_bcd_s2};
    end else begin : g_shift_single
      assign w_shifted = r_bcd_s2;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_digits   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_timeout  <= 1'b0;
      r_timer    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_digits   <= w_digits_nxt;
      r_count    <= w_count_nxt;
      r_overflow <= w_overflow_nxt;
      r_timeout  <= w_timeout_nxt;
      r_timer    <= w_timer_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_digits_nxt   = r_digits;
    w_count_nxt    = r_count;
    w_overflow_nxt = r_overflow;
    w_timer_nxt    = r_timer;
    w_timeout_nxt  = 1'b0;
    w_enc_enablen  = 1'b1;
    w_busy         = 1'b0;
    w_code_valid   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_nxt    = ST_ENTRY;
          w_digits_nxt   = '0;
          w_count_nxt    = '0;
          w_overflow_nxt = 1'b0;
          w_timer_nxt    = '0;
        end
      end

      ST_ENTRY: begin
        w_enc_enablen = 1'b0;
        w_busy        = 1'b1;
        if (bus.start) begin
          // Restart: identical clears to a fresh start from IDLE.
          w_digits_nxt   = '0;
          w_count_nxt    = '0;
          w_overflow_nxt = 1'b0;
          w_timer_nxt    = '0;
        end else if (bus.clear) begin
          // Any digit arriving in this cycle is dropped; overflow survives.
          w_digits_nxt = '0;
          w_count_nxt  = '0;
          w_timer_nxt  = '0;
        end else begin
          if (w_accept) begin
            w_timer_nxt = '0;
            if (r_count < C_FULL) begin
              w_digits_nxt = w_shifted;
              w_count_nxt  = r_count + 1'b1;
            end else begin
              w_overflow_nxt = 1'b1;
            end
          end else begin
            w_timer_nxt = r_timer + 1'b1;
          end

          // A digit accepted alongside commit is part of the published code.
          if (bus.commit && ((r_count != '0) || w_accept)) begin
            w_state_nxt = ST_DONE;
            w_timer_nxt = '0;
          end else if (!w_accept && (r_timer == C_TMR_LAST)) begin
            w_state_nxt   = ST_IDLE;
            w_timeout_nxt = 1'b1;
            w_digits_nxt  = '0;
            w_count_nxt   = '0;
            w_timer_nxt   = '0;
          end
        end
      end

      ST_DONE: begin
        w_busy       = 1'b1;
        w_code_valid = 1'b1;
        w_state_nxt  = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.enc_enablen = w_enc_enablen;
  assign bus.busy        = w_busy;
  assign bus.code_valid  = w_code_valid;
  assign bus.digits      = r_digits;
  assign bus.digit_count = r_count;
  assign bus.overflow    = r_overflow;
  assign bus.timeout     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_keypad_entry_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_keypad_entry_ctrl                                         |
// | Description : Directed self-checking bench for keypad_entry_ctrl.          |
// |               Inputs change on the falling edge; outputs are sampled on    |
// |               the falling edge, half a cycle away from the active edge.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_keypad_entry_ctrl;

  localparam int NDIGITS     = 4;
  localparam int TIMEOUT_CYC = 1000;
  localparam int TMR_W       = 10;

  logic clk;
  logic rst_n;

  int n_checks;
  int n_fail;

  keypad_entry_if #(.NDIGITS(NDIGITS)) kif ();

  keypad_entry_ctrl #(
    .NDIGITS     (NDIGITS),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TMR_W       (TMR_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk); kif.start = 1'b1;
    @(negedge clk); kif.start = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk); kif.clear = 1'b1;
    @(negedge clk); kif.clear = 1'b0;
  endtask

  // Key press: valid high for 4 cycles, then low for 4 cycles.
  task automatic press(input logic [3:0] d);
    @(negedge clk);
    kif.bcd_in    = d;
    kif.bcd_valid = 1'b1;
    tick(4);
    kif.bcd_valid = 1'b0;
    tick(4);
  endtask

  // Commit expected to be honoured: code_valid for exactly one cycle.
  task automatic commit_expect(input string tag, input logic [31:0] exp_digits,
                               input logic [31:0] exp_count);
    @(negedge clk); kif.commit = 1'b1;
    @(negedge clk); kif.commit = 1'b0;
    check({tag, "_cv"},    32'(kif.code_valid),  32'd1);
    check({tag, "_en"},    32'(kif.enc_enablen), 32'd1);
    check({tag, "_busy"},  32'(kif.busy),        32'd1);
    check({tag, "_dig"},   32'(kif.digits),      exp_digits);
    check({tag, "_cnt"},   32'(kif.digit_count), exp_count);
    @(negedge clk);
    check({tag, "_cv_off"}, 32'(kif.code_valid), 32'd0);
    check({tag, "_idle"},   32'(kif.busy),       32'd0);
    check({tag, "_hold"},   32'(kif.digits),     exp_digits);
  endtask

  initial begin
    int  cyc;
    bit  seen_cv;

    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    kif.start     = 1'b0;
    kif.clear     = 1'b0;
    kif.commit    = 1'b0;
    kif.bcd_in    = 4'd0;
    kif.bcd_valid = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);

    // ---- reset values ----
    check("rst_en",   32'(kif.enc_enablen), 32'd1);
    check("rst_dig",  32'(kif.digits),      32'd0);
    check("rst_cnt",  32'(kif.digit_count), 32'd0);
    check("rst_busy", 32'(kif.busy),        32'd0);
    check("rst_ovf",  32'(kif.overflow),    32'd0);
    check("rst_to",   32'(kif.timeout),     32'd0);
    check("rst_cv",   32'(kif.code_valid),  32'd0);

    // ---- 1: basic three-digit entry ----
    pulse_start();
    check("t1_en_entry",   32'(kif.enc_enablen), 32'd0);
    check("t1_busy_entry", 32'(kif.busy),        32'd1);
    press(4'd1);
    press(4'd2);
    press(4'd3);
    check("t1_dig_pre", 32'(kif.digits), 32'h123);
    commit_expect("t1", 32'h0123, 32'd3);

    // ---- 2: overflow with NDIGITS=4 ----
    pulse_start();
    check("t2_cnt_start", 32'(kif.digit_count), 32'd0);
    press(4'd9);
    press(4'd8);
    press(4'd7);
    press(4'd6);
    check("t2_ovf_before", 32'(kif.overflow), 32'd0);
    press(4'd5);
    check("t2_ovf", 32'(kif.overflow), 32'd1);
    commit_expect("t2", 32'h9876, 32'd4);
    check("t2_ovf_sticky", 32'(kif.overflow), 32'd1);

    // ---- 3: clear mid-entry ----
    pulse_start();
    check("t3_ovf_cleared", 32'(kif.overflow), 32'd0);
    press(4'd4);
    press(4'd2);
    check("t3_dig_42", 32'(kif.digits), 32'h42);
    pulse_clear();
    check("t3_cnt_clr", 32'(kif.digit_count), 32'd0);
    press(4'd7);
    commit_expect("t3", 32'h0007, 32'd1);

    // clear coinciding with the synced valid edge drops the digit
    pulse_start();
    press(4'd3);
    @(negedge clk); kif.bcd_in = 4'd8; kif.bcd_valid = 1'b1;
    @(negedge clk);
    @(negedge clk); kif.clear = 1'b1;
    @(negedge clk); kif.clear = 1'b0;
    tick(3);
    kif.bcd_valid = 1'b0;
    tick(4);
    check("t3_drop_cnt", 32'(kif.digit_count), 32'd0);
    check("t3_drop_dig", 32'(kif.digits),      32'd0);

    // commit with nothing entered is ignored
    @(negedge clk); kif.commit = 1'b1;
    @(negedge clk); kif.commit = 1'b0;
    check("t3_c0_cv",   32'(kif.code_valid),  32'd0);
    check("t3_c0_busy", 32'(kif.busy),        32'd1);
    check("t3_c0_en",   32'(kif.enc_enablen), 32'd0);

    // ---- 4: idle timeout ----
    pulse_start();
    cyc     = 0;
    seen_cv = 1'b0;
    while (cyc < TIMEOUT_CYC + 200) begin
      @(negedge clk);
      cyc++;
      if (kif.code_valid) seen_cv = 1'b1;
      if (kif.timeout) break;
    end
    check("t4_to_seen",  32'(kif.timeout),     32'd1);
    check("t4_to_cyc",   32'(cyc),             32'(TIMEOUT_CYC));
    check("t4_busy",     32'(kif.busy),        32'd0);
    check("t4_en",       32'(kif.enc_enablen), 32'd1);
    check("t4_cnt",      32'(kif.digit_count), 32'd0);
    check("t4_no_cv",    32'(seen_cv),         32'd0);
    @(negedge clk);
    check("t4_to_pulse", 32'(kif.timeout),     32'd0);

    // ---- 5: held key and non-decimal code ----
    pulse_start();
    @(negedge clk); kif.bcd_in = 4'd5; kif.bcd_valid = 1'b1;
    tick(50);
    kif.bcd_valid = 1'b0;
    tick(5);
    check("t5_held_cnt", 32'(kif.digit_count), 32'd1);
    check("t5_held_dig", 32'(kif.digits),      32'h5);
    press(4'd15);
    check("t5_bad_cnt", 32'(kif.digit_count), 32'd1);
    check("t5_bad_ovf", 32'(kif.overflow),    32'd0);
    press(4'd6);
    commit_expect("t5", 32'h0056, 32'd2);

    // ---- 6: asynchronous reset mid-entry ----
    pulse_start();
    press(4'd1);
    press(4'd2);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_en",   32'(kif.enc_enablen), 32'd1);
    check("t6_busy", 32'(kif.busy),        32'd0);
    check("t6_dig",  32'(kif.digits),      32'd0);
    check("t6_cnt",  32'(kif.digit_count), 32'd0);
    check("t6_ovf",  32'(kif.overflow),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);
    check("t6_idle_busy", 32'(kif.busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
